// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 7;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor; master issues operands, slave returns results.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell: d = x - y - bi, bo is the borrow out of this bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles using one full-subtractor cell.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] r_next;
  logic             accept;

  full_subtractor u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts the full result is aligned.
  assign r_next = {cell_d, r_sr};

  // The DONE cycle doubles as an accept slot so a held start repeats every WIDTH+1 cycles.
  assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_sr       <= bus.a;
        b_sr       <= bus.b;
        r_sr       <= '0;
        borrow_reg <= bus.bin;
        a_msb_reg  <= bus.a[WIDTH-1];
        b_msb_reg  <= bus.b[WIDTH-1];
        cnt_reg    <= '0;
        busy_reg   <= 1'b1;
        state_reg  <= SHIFT;
      end else begin
        case (state_reg)
          SHIFT: begin
            a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr       <= r_next[WIDTH-1:1];
            borrow_reg <= cell_bo;
            cnt_reg    <= cnt_reg + CW'(1);
            if (cnt_reg == CW'(WIDTH - 1)) begin
              diff_reg  <= r_next;
              bout_reg  <= cell_bo;
              // Overflow only when operand signs differ and the result sign departs from a.
              ovf_reg   <= (a_msb_reg ^ b_msb_reg) & (cell_d ^ a_msb_reg);
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: fixed vectors with hand-computed results and cycle-exact handshake checks.
module tb_serial_subtractor;

  localparam int W = 7;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   prev_diff;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble them to prove they were captured.
  task automatic start_op(input int a, input int b, input int bin);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = W'(a);
    sif.b     = W'(b);
    sif.bin   = bin[0];
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.a     = ~sif.a;
    sif.b     = ~sif.b;
    sif.bin   = ~sif.bin;
  endtask

  task automatic expect_op(input int a, input int b, input int bin, input int ediff,
                           input int ebout, input int eovf, input bit pulse_mid);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_high", 32'(sif.busy), 32'd1);
      check("done_low_busy", 32'(sif.done), 32'd0);
      check("diff_hold", 32'(sif.diff), 32'(prev_diff));
      if (pulse_mid && i == 2) sif.start = 1'b1;
      if (pulse_mid && i == 3) sif.start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'(sif.done), 32'd1);
    check("busy_end", 32'(sif.busy), 32'd0);
    check("diff", 32'(sif.diff), 32'(ediff));
    check("bout", 32'(sif.bout), 32'(ebout));
    check("ovf", 32'(sif.ovf), 32'(eovf));
    $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d", a, b, bin,
             sif.diff, sif.bout, sif.ovf);
    prev_diff = ediff;
    @(negedge clk);
    check("done_single", 32'(sif.done), 32'd0);
    check("idle_after", 32'(sif.busy), 32'd0);
  endtask

  task automatic run_op(input int a, input int b, input int bin, input int ediff,
                        input int ebout, input int eovf, input bit pulse_mid);
    start_op(a, b, bin);
    expect_op(a, b, bin, ediff, ebout, eovf, pulse_mid);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_diff = 0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.bin   = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_diff", 32'(sif.diff), 32'd0);
    check("rst_bout", 32'(sif.bout), 32'd0);
    check("rst_ovf", 32'(sif.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(25, 10, 0, 15, 0, 0, 1'b0);
    run_op(10, 25, 0, 113, 1, 0, 1'b0);
    run_op(0, 0, 1, 127, 1, 0, 1'b0);
    run_op(64, 1, 0, 63, 0, 1, 1'b0);
    run_op(63, 127, 0, 64, 1, 1, 1'b0);

    // Asynchronous reset in the middle of a shift: outputs clear before the next edge.
    start_op(25, 10, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(sif.busy), 32'd0);
    check("midrst_done", 32'(sif.done), 32'd0);
    check("midrst_diff", 32'(sif.diff), 32'd0);
    check("midrst_bout", 32'(sif.bout), 32'd0);
    check("midrst_ovf", 32'(sif.ovf), 32'd0);
    prev_diff = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(sif.done), 32'd0);
      check("midrst_no_busy", 32'(sif.busy), 32'd0);
    end

    run_op(0, 1, 0, 127, 1, 0, 1'b1);
    run_op(127, 0, 1, 126, 0, 0, 1'b0);

    // start held high: second operation is accepted on the completion-cycle edge.
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = W'(50);
    sif.b     = W'(20);
    sif.bin   = 1'b0;
    @(posedge clk);
    #1;
    sif.a = W'(100);
    sif.b = W'(3);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("b2b1_busy", 32'(sif.busy), 32'd1);
      check("b2b1_hold", 32'(sif.diff), 32'(prev_diff));
    end
    @(negedge clk);
    check("b2b1_done", 32'(sif.done), 32'd1);
    check("b2b1_diff", 32'(sif.diff), 32'd30);
    check("b2b1_bout", 32'(sif.bout), 32'd0);
    $display("op a=50 b=20 bin=0 -> diff=%0d bout=%0d ovf=%0d", sif.diff, sif.bout, sif.ovf);
    prev_diff = 30;
    @(posedge clk);
    #1;
    sif.a = W'(5);
    sif.b = W'(9);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("b2b2_busy", 32'(sif.busy), 32'd1);
      check("b2b2_done_low", 32'(sif.done), 32'd0);
      check("b2b2_hold", 32'(sif.diff), 32'(prev_diff));
    end
    @(negedge clk);
    check("b2b2_done", 32'(sif.done), 32'd1);
    check("b2b2_diff", 32'(sif.diff), 32'd97);
    check("b2b2_bout", 32'(sif.bout), 32'd0);
    check("b2b2_ovf", 32'(sif.ovf), 32'd0);
    $display("op a=100 b=3 bin=0 -> diff=%0d bout=%0d ovf=%0d", sif.diff, sif.bout, sif.ovf);
    sif.start = 1'b0;
    @(negedge clk);
    check("b2b_end_done", 32'(sif.done), 32'd0);
    check("b2b_end_busy", 32'(sif.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
